// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl codes (common with the ALU decoder)
// and the execute-stage multiplier FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALUCTRL_ADD  = 4'b0000;
    localparam logic [3:0] ALUCTRL_SUB  = 4'b0001;
    localparam logic [3:0] ALUCTRL_AND  = 4'b0010;
    localparam logic [3:0] ALUCTRL_OR   = 4'b0011;
    localparam logic [3:0] ALUCTRL_XOR  = 4'b0100;
    localparam logic [3:0] ALUCTRL_SLT  = 4'b1000;
    localparam logic [3:0] ALUCTRL_SLTU = 4'b1001;
    localparam logic [3:0] ALUCTRL_MUL  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WAIT = 2'd2
    } alu_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle for XLEN cycles.
// Only instantiated when ALU_MUL_EN is defined.
module mul_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] mcand_in,
    input  logic [XLEN-1:0] mplr_in,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplr;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_next;
    logic [CW-1:0]   cnt;
    logic            run;

    assign acc_next = mplr[0] ? acc + mcand : acc;
    assign done     = run && (cnt == LAST);
    // While running, expose the value acc takes at this edge so the final
    // iteration can be written straight into the output register.
    assign product  = run ? acc_next : acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            run   <= 1'b0;
        end else if (abort) begin
            run <= 1'b0;
        end else if (start) begin
            mcand <= mcand_in;
            mplr  <= mplr_in;
            acc   <= '0;
            cnt   <= '0;
            run   <= 1'b1;
        end else if (run) begin
            acc   <= acc_next;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// RV32 execute-stage ALU with registered result/zero and valid/ready handshake.
// MUL via iterative multiplier only when ALU_MUL_EN is defined; otherwise 1010 acts as ADD.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    logic [XLEN-1:0] alu_res;
    logic            free;
    logic            accept;

    always_comb begin
        alu_res = src_a + src_b;
        case (alu_ctrl)
            ALUCTRL_SUB:  alu_res = src_a - src_b;
            ALUCTRL_AND:  alu_res = src_a & src_b;
            ALUCTRL_OR:   alu_res = src_a | src_b;
            ALUCTRL_XOR:  alu_res = src_a ^ src_b;
            ALUCTRL_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALUCTRL_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            default:      alu_res = src_a + src_b;
        endcase
    end

    assign free = !out_valid || out_ready;

`ifdef ALU_MUL_EN
    alu_state_t      state;
    logic            is_mul;
    logic            mul_done;
    logic [XLEN-1:0] product;

    assign is_mul   = (alu_ctrl == ALUCTRL_MUL);
    assign in_ready = rst_n && (state == IDLE) && free && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    mul_iter #(.XLEN(XLEN)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept && is_mul),
        .abort    (flush),
        .mcand_in (src_a),
        .mplr_in  (src_b),
        .done     (mul_done),
        .product  (product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= MUL;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        if (free) begin
                            result    <= product;
                            zero      <= (product == '0);
                            out_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (free) begin
                        result    <= product;
                        zero      <= (product == '0);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign in_ready = rst_n && free && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                result    <= alu_res;
                zero      <= (alu_res == '0);
                out_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed vectors push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_alu_exec;
    import alu_pkg::*;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MUL_LAT = MUL_EN ? 33 : 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every output handshake pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output actual=%h required=none", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (result !== e.res || zero !== e.z) begin
                    errors++;
                    $display("FAIL result actual=%h/%b required=%h/%b", result, zero, e.res, e.z);
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input bit push);
        bit ok;
        ok       = 1'b0;
        alu_ctrl = c;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (push) exp_q.push_back({expv, (expv == 32'd0)});
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
        end
    endtask

    // Measures cycles from accept to out_valid and checks in_ready/busy meanwhile.
    task automatic mul_timed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        int lat;
        bit early_ready;
        bit busy1;
        lat = 0;
        early_ready = 1'b0;
        busy1 = 1'b0;
        issue(ALUCTRL_MUL, a, b, expv, 1'b1);
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = busy;
            if (out_valid) lat = k;
            else if (in_ready) early_ready = 1'b1;
        end
        check("mul_latency", lat, MUL_LAT);
        check("mul_in_ready_low", {31'd0, early_ready}, 32'd0);
        check("mul_busy", {31'd0, busy1}, {31'd0, MUL_EN});
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        alu_ctrl  = ALUCTRL_ADD;
        src_a     = 32'd1;
        src_b     = 32'd1;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_zero", {31'd0, zero}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        issue(ALUCTRL_ADD, 32'd5, 32'd7, 32'd12, 1'b1);
        @(negedge clk);
        check("add_latency", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back single-cycle ops: each accept pops the previous result.
        issue(ALUCTRL_SUB,  32'd9,         32'd9,         32'd0,          1'b1);
        issue(ALUCTRL_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,          1'b1);
        issue(ALUCTRL_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,          1'b1);
        issue(4'b0111,      32'd3,         32'd4,         32'd7,          1'b1);
        issue(ALUCTRL_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000,  1'b1);
        issue(ALUCTRL_OR,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0,  1'b1);
        issue(ALUCTRL_XOR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0,  1'b1);
        issue(ALUCTRL_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF,  1'b1);
        issue(ALUCTRL_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0,          1'b1);
        repeat (2) @(posedge clk);
        #1;

        mul_timed(32'h0001_0003, 32'h0000_0005, MUL_EN ? 32'h0005_000F : 32'h0001_0008);
        @(posedge clk);
        #1;
        mul_timed(32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_EN ? 32'h0000_0001 : 32'hFFFF_FFFE);
        @(posedge clk);
        #1;

        // Consumer stalled: MUL result must sit stable until popped.
        out_ready = 1'b0;
        mul_timed(32'd7, 32'd6, MUL_EN ? 32'd42 : 32'd13);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_result", result, MUL_EN ? 32'd42 : 32'd13);
            check("hold_valid_ready", {30'd0, out_valid, in_ready}, 32'b10);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(ALUCTRL_ADD, 32'd8, 32'd8, 32'd16, 1'b1);
        @(posedge clk);
        #1;

        // Flush kills a held result but leaves result/zero stale.
        out_ready = 1'b0;
        issue(ALUCTRL_ADD, 32'd6, 32'd6, 32'd12, 1'b0);
        @(negedge clk);
        check("held_before_flush", {out_valid, result[30:0]}, {1'b1, 31'd12});
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_stale_result", result, 32'd12);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

`ifdef ALU_MUL_EN
        // Flush during the 10th multiplier iteration.
        issue(ALUCTRL_MUL, 32'd3, 32'd5, 32'd15, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("mul_flush_ready", {30'd0, in_ready, busy}, 32'b10);
        seen = out_valid;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("mul_flush_no_output", {31'd0, seen}, 32'd0);
        @(posedge clk);
        #1;
`endif

        issue(ALUCTRL_ADD, 32'd1, 32'd1, 32'd2, 1'b1);
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
